// File: rtl/mod_m_down_timer.sv
// rtl/mod_m_down_timer.sv - loadable modulo-M down-counter with underflow tick
module mod_m_down_timer #(
   parameter int N           = 4,
   parameter int M           = 10,
   parameter bit AUTO_RELOAD = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] d,
   input  logic         start,
   input  logic         en,
   output logic [N-1:0] q,
   output logic         min_tick,
   output logic         busy
);

   // Largest count the timer may hold; loaded values saturate here.
   localparam logic [N-1:0] MAX_Q = N'(M - 1);

   // Local state encoding.
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic         state_q,  state_d;
   logic [N-1:0] count_q,  count_d;
   logic [N-1:0] reload_q, reload_d;
   logic         tick_q,   tick_d;

   function automatic logic [N-1:0] clamp(input logic [N-1:0] x);
      return (x > MAX_Q) ? MAX_Q : x;
   endfunction

   // Next-state logic: load beats start beats an enabled step.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      tick_d   = 1'b0;
      if (load) begin
         reload_d = clamp(d);
         count_d  = clamp(d);
         state_d  = ST_RUN;
      end else if (start) begin
         count_d = reload_q;
         state_d = ST_RUN;
      end else if (state_q == ST_RUN && en) begin
         if (count_q != '0) begin
            count_d = count_q - 1'b1;
         end else begin
            // Underflow: tick, then either wrap to the reload value or park at 0.
            tick_d = 1'b1;
            if (AUTO_RELOAD) begin
               count_d = reload_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   // State, count, reload and tick registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         reload_q <= MAX_Q;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         tick_q   <= tick_d;
      end
   end

   assign q        = count_q;
   assign min_tick = tick_q;
   assign busy     = (state_q == ST_RUN);

endmodule
